// File: rtl/dmem_ctrl.sv
// Data memory controller: valid/ready load/store front end over an internal RAM with wait states and error reporting.
// Optional macro DMEM_MISALIGN_EXC_EN turns misaligned H/W/D accesses into errors instead of aligning them down.
`timescale 1ns/1ps
module dmem_ctrl #(
  parameter int XLEN        = 64,
  parameter int DEPTH       = 256,
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            W_en,
  input  logic            R_en,
  input  logic [AW-1:0]   addr,
  input  logic [2:0]      RW_type,
  input  logic [XLEN-1:0] WD,
  output logic [XLEN-1:0] RD,
  output logic            done,
  output logic            err
);

  localparam int          NB     = XLEN / 8;
  localparam int          OB     = $clog2(NB);
  localparam int          IW     = $clog2(DEPTH);
  localparam logic [63:0] BYTES  = 64'(DEPTH) * 64'(NB);
  localparam logic [3:0]  WAIT_L = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state;
  logic [3:0]      cnt;
  logic            w_p0, r_p0;
  logic [AW-1:0]   addr_p0;
  logic [2:0]      type_p0;
  logic [XLEN-1:0] wd_p0;

  logic            s_w, s_r, misal, illegal, commit;
  logic [AW-1:0]   s_addr;
  logic [2:0]      s_type;
  logic [XLEN-1:0] s_wd;
  logic [OB-1:0]   szm, lane;
  logic [IW-1:0]   idx;
  logic [XLEN-1:0] old_word, new_word, wr_shift, rd_shift;

  logic [XLEN-1:0] mem [DEPTH];

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] v, input logic [2:0] t);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sb = v[7:0];
    sh = v[15:0];
    sw = v[31:0];
    case (t)
      3'b000:  load_ext = XLEN'(sb);
      3'b001:  load_ext = XLEN'(sh);
      3'b010:  load_ext = XLEN'(sw);
      3'b100:  load_ext = XLEN'(v[7:0]);
      3'b101:  load_ext = XLEN'(v[15:0]);
      3'b110:  load_ext = XLEN'(v[31:0]);
      default: load_ext = v;
    endcase
  endfunction

  assign req_ready = (state == S_IDLE);

  // With no wait states the commit edge is the accept edge, so decode straight from the ports in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      s_w    = W_en;
      s_r    = R_en;
      s_addr = addr;
      s_type = RW_type;
      s_wd   = WD;
    end else begin
      s_w    = w_p0;
      s_r    = r_p0;
      s_addr = addr_p0;
      s_type = type_p0;
      s_wd   = wd_p0;
    end

    szm = OB'((4'd1 << s_type[1:0]) - 4'd1);
`ifdef DMEM_MISALIGN_EXC_EN
    misal = |(s_addr[OB-1:0] & szm);
    lane  = s_addr[OB-1:0];
`else
    misal = 1'b0;
    lane  = s_addr[OB-1:0] & ~szm;
`endif

    illegal = (s_w && s_r) || (64'(s_addr) >= BYTES) || (s_type == 3'b111) ||
              (s_w && s_type[2]) ||
              ((XLEN == 32) && ((s_type == 3'b011) || (s_type == 3'b110))) || misal;

    commit = rst_n && (((state == S_IDLE) && req_valid && (WAIT_L == 4'd0)) ||
                       ((state == S_WAIT) && (cnt == WAIT_L)));

    idx      = s_addr[OB+IW-1:OB];
    old_word = mem[idx];
    rd_shift = old_word >> {lane, 3'b000};
    wr_shift = s_wd << {lane, 3'b000};
    new_word = old_word;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(lane)) && (b <= int'(lane) + int'(szm)))
        new_word[8*b +: 8] = wr_shift[8*b +: 8];
    end
  end

  // Request capture at accept; data path carries no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && req_valid) begin
      w_p0    <= W_en;
      r_p0    <= R_en;
      addr_p0 <= addr;
      type_p0 <= RW_type;
      wd_p0   <= WD;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && s_w && !illegal)
      mem[idx] <= new_word;
  end

  // Control FSM and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
      err   <= 1'b0;
      RD    <= '0;
    end else begin
      done <= commit;
      err  <= commit && illegal;
      if (commit && s_r && !illegal)
        RD <= load_ext(rd_shift, s_type);
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (WAIT_L == 4'd0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_L) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a byte-array transaction model checked every cycle, plus directed literal checks.
// Two instances: WAIT_CYCLES=1 (main) and WAIT_CYCLES=0 (back-to-back throughput).
`timescale 1ns/1ps
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        w_en      [2];
  logic        r_en      [2];
  logic        done      [2];
  logic        err       [2];
  logic [31:0] addr      [2];
  logic [2:0]  rw_type   [2];
  logic [63:0] wd        [2];
  logic [63:0] rd        [2];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_ctrl #(.XLEN(64), .DEPTH(256), .AW(32), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .W_en(w_en[0]), .R_en(r_en[0]), .addr(addr[0]), .RW_type(rw_type[0]),
    .WD(wd[0]), .RD(rd[0]), .done(done[0]), .err(err[0]));

  dmem_ctrl #(.XLEN(64), .DEPTH(256), .AW(32), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .W_en(w_en[1]), .R_en(r_en[1]), .addr(addr[1]), .RW_type(rw_type[1]),
    .WD(wd[1]), .RD(rd[1]), .done(done[1]), .err(err[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h12345600 + 32'(i)};
  endfunction

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory as bytes, one outstanding request per instance.
  logic [7:0]  mb [2][2048];
  logic [63:0] m_rd [2];
  longint      cyc = 0;
  longint      next_free [2];
  longint      commit_at [2];
  bit          pend [2];
  bit          p_w [2], p_r [2];
  logic [31:0] p_a [2];
  logic [2:0]  p_t [2];
  logic [63:0] p_wd [2];
  bit          exp_done [2], exp_err [2];

  task automatic model_commit(input int d);
    int          sz;
    longint      a, base;
    logic [63:0] v;
    bit          e;
    sz = 1 << p_t[d][1:0];
    a  = longint'(p_a[d]);
    e  = (p_w[d] && p_r[d]) || (a >= 2048) || (p_t[d] == 3'b111) || (p_w[d] && p_t[d][2]);
`ifdef DMEM_MISALIGN_EXC_EN
    if ((a % sz) != 0) e = 1'b1;
`endif
    base = a - (a % sz);
    if (!e && p_w[d])
      for (int i = 0; i < sz; i++) mb[d][base + i] = p_wd[d][8*i +: 8];
    if (!e && p_r[d]) begin
      v = 64'd0;
      for (int i = 0; i < sz; i++) v |= 64'(mb[d][base + i]) << (8 * i);
      if ((p_t[d] < 3'd3) && v[8*sz-1]) v |= ~((64'd1 << (8 * sz)) - 64'd1);
      m_rd[d] = v;
    end
    exp_err[d] = e;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      next_free[d] = 0; commit_at[d] = 0; pend[d] = 0; m_rd[d] = 64'd0;
      exp_done[d] = 0; exp_err[d] = 0;
      for (int i = 0; i < 2048; i++) mb[d][i] = 8'h00;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        exp_done[d] = 0;
        if (!rst_n) begin
          pend[d] = 0; next_free[d] = 0; m_rd[d] = 64'd0;
        end else begin
          if ((cyc >= next_free[d]) && (req_valid[d] === 1'b1)) begin
            p_w[d] = w_en[d]; p_r[d] = r_en[d]; p_a[d] = addr[d];
            p_t[d] = rw_type[d]; p_wd[d] = wd[d];
            commit_at[d] = cyc + wc(d);
            next_free[d] = cyc + wc(d) + 2;
            pend[d] = 1;
          end
          if (pend[d] && (commit_at[d] == cyc)) begin
            model_commit(d);
            pend[d] = 0;
            exp_done[d] = 1;
          end
        end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        check1($sformatf("dut%0d done", d), done[d], exp_done[d]);
        check1($sformatf("dut%0d req_ready", d), req_ready[d], (cyc + 1) >= next_free[d]);
        check64($sformatf("dut%0d RD", d), rd[d], m_rd[d]);
        if (exp_done[d]) check1($sformatf("dut%0d err", d), err[d], exp_err[d]);
      end
    end
  end

  task automatic do_req(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [2:0] t, input logic [63:0] data,
                        output logic [63:0] rdo, output logic eo, output int lat);
    int k;
    @(negedge clk);
    w_en[d] = w; r_en[d] = r; addr[d] = a; rw_type[d] = t; wd[d] = data;
    req_valid[d] = 1'b1;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL dut%0d accept timeout: ready stayed 0, expected 1", d);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid[d] = 1'b0;
    end while (!done[d] && lat < 50);
    if (lat >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL dut%0d done timeout: done stayed 0, expected 1", d);
    end
    rdo = rd[d];
    eo  = err[d];
  endtask

  initial begin
    logic [63:0] r;
    logic        e;
    int          l, k, nd, nrl;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; w_en[d] = 1'b0; r_en[d] = 1'b0;
      addr[d] = 32'd0; rw_type[d] = 3'd0; wd[d] = 64'd0;
    end
    repeat (3) @(negedge clk);
    check1("reset req_ready", req_ready[0], 1'b1);
    check1("reset done", done[0], 1'b0);
    check64("reset RD", rd[0], 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) do_req(0, 1'b1, 1'b0, 32'(i * 8), 3'b011, pat(i), r, e, l);

    do_req(0, 1'b1, 1'b0, 32'h10, 3'b011, 64'h8877665544332211, r, e, l);
    check1("store D err", e, 1'b0);
    check64("store D latency", 64'(l), 64'd2);
    do_req(0, 1'b0, 1'b1, 32'h10, 3'b011, 64'd0, r, e, l);
    check64("load D data", r, 64'h8877665544332211);
    check64("load D latency", 64'(l), 64'd2);

    do_req(0, 1'b1, 1'b0, 32'h13, 3'b000, 64'h00000000000000F0, r, e, l);
    do_req(0, 1'b0, 1'b1, 32'h13, 3'b000, 64'd0, r, e, l);
    check64("load B sext", r, 64'hFFFFFFFFFFFFFFF0);
    do_req(0, 1'b0, 1'b1, 32'h13, 3'b100, 64'd0, r, e, l);
    check64("load BU", r, 64'h00000000000000F0);
    do_req(0, 1'b0, 1'b1, 32'h10, 3'b011, 64'd0, r, e, l);
    check64("load D after byte store", r, 64'h88776655F0332211);
    do_req(0, 1'b0, 1'b1, 32'h12, 3'b001, 64'd0, r, e, l);
    check64("load H sext", r, 64'hFFFFFFFFFFFFF033);
    do_req(0, 1'b0, 1'b1, 32'h16, 3'b101, 64'd0, r, e, l);
    check64("load HU", r, 64'h0000000000008877);
    do_req(0, 1'b0, 1'b1, 32'h14, 3'b010, 64'd0, r, e, l);
    check64("load W sext", r, 64'hFFFFFFFF88776655);
    do_req(0, 1'b0, 1'b1, 32'h14, 3'b110, 64'd0, r, e, l);
    check64("load WU", r, 64'h0000000088776655);

    do_req(0, 1'b0, 1'b1, 32'h800, 3'b011, 64'd0, r, e, l);
    check1("out of range err", e, 1'b1);
    check64("out of range RD held", r, 64'h0000000088776655);
    do_req(0, 1'b1, 1'b1, 32'h10, 3'b011, 64'hDEADBEEFDEADBEEF, r, e, l);
    check1("W and R err", e, 1'b1);
    do_req(0, 1'b0, 1'b1, 32'h111, 3'b111, 64'd0, r, e, l);
    check1("type 111 err", e, 1'b1);
    do_req(0, 1'b1, 1'b0, 32'h10, 3'b100, 64'h00000000000000AA, r, e, l);
    check1("store BU err", e, 1'b1);
    do_req(0, 1'b0, 1'b1, 32'h10, 3'b011, 64'd0, r, e, l);
    check64("RAM unchanged after errors", r, 64'h88776655F0332211);

    do_req(0, 1'b0, 1'b1, 32'h12, 3'b010, 64'd0, r, e, l);
`ifdef DMEM_MISALIGN_EXC_EN
    check1("misaligned W err", e, 1'b1);
    check64("misaligned W RD held", r, 64'h88776655F0332211);
`else
    check1("misaligned W err", e, 1'b0);
    check64("misaligned W aligned down", r, 64'hFFFFFFFFF0332211);
`endif
    do_req(0, 1'b0, 1'b0, 32'h10, 3'b011, 64'd0, r, e, l);
    check1("no-op err", e, 1'b0);

    // Reset asserted while a store to 0x20 is waiting.
    @(negedge clk);
    w_en[0] = 1'b1; r_en[0] = 1'b0; addr[0] = 32'h20; rw_type[0] = 3'b011;
    wd[0] = 64'h1111111111111111; req_valid[0] = 1'b1;
    k = 0;
    while (!req_ready[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("mid-op reset req_ready", req_ready[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("mid-op reset done", done[0], 1'b0);
    end
    rst_n = 1'b1;
    do_req(0, 1'b0, 1'b1, 32'h20, 3'b011, 64'd0, r, e, l);
    check64("store dropped by reset", r, 64'hC0DE000412345604);

    do_req(1, 1'b1, 1'b0, 32'h40, 3'b011, 64'h0123456789ABCDEF, r, e, l);
    check64("wait0 store latency", 64'(l), 64'd1);
    do_req(1, 1'b0, 1'b1, 32'h40, 3'b011, 64'd0, r, e, l);
    check64("wait0 load data", r, 64'h0123456789ABCDEF);
    check64("wait0 load latency", 64'(l), 64'd1);

    @(negedge clk);
    w_en[1] = 1'b0; r_en[1] = 1'b1; addr[1] = 32'h40; rw_type[1] = 3'b011;
    req_valid[1] = 1'b1;
    nd = 0; nrl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done[1]) begin
        nd++;
        if (!req_ready[1]) nrl++;
      end
    end
    req_valid[1] = 1'b0;
    check64("back-to-back done count", 64'(nd), 64'd5);
    check64("ready low in RESP count", 64'(nrl), 64'd5);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
